// File: rtl/n_bit_piso_register_pkg.sv
// Shared types and defaults for the parallel-in/serial-out register.
// Configuration macro PISO_LSB_FIRST_EN (bit order) is consumed by the top, not here.
package piso_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/n_bit_piso_register_if.sv
// Word handshake and serial output bundle of the PISO register.
// master = word source / serial sink side, slave = the PISO register itself.
interface n_bit_piso_register_if #(
    parameter int N = piso_pkg::DEFAULT_WIDTH
);
    logic         load;
    logic [N-1:0] in;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         done;

    modport master (
        output load,
        output in,
        input  ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  load,
        input  in,
        output ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/n_bit_piso_register_bit_counter.sv
// Bit position counter for the PISO register: counts 0..N-1 within a word.
// last flags the final bit position so the FSM can hand over to the next word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/n_bit_piso_register.sv
// N-bit parallel-in/serial-out register with load/ready handshake and last-bit flag.
// Define PISO_LSB_FIRST_EN to transmit bit 0 first; default build sends MSB first.
//   state | meaning
//   IDLE  | no word in flight, ready for a new one
//   SHIFT | a word is being shifted out, one bit per cycle
module n_bit_piso_register
    import piso_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input logic                  clk,
    input logic                  rst,
    n_bit_piso_register_if.slave bus
);

    piso_state_t   state;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shifted;
    logic          head;
    logic [CW-1:0] cnt;
    logic          last;
    logic          accept;
    logic          cnt_clear;
    logic          cnt_en;

`ifdef PISO_LSB_FIRST_EN
    assign shifted = {1'b0, shreg[N-1:1]};
    assign head    = shreg[0];
`else
    assign shifted = {shreg[N-2:0], 1'b0};
    assign head    = shreg[N-1];
`endif

    // Ready opens on the last bit too, which is what lets words stream gap-free.
    assign bus.ready      = (state == IDLE) | last;
    assign bus.done       = (state == SHIFT) & (cnt == CW'(N - 1));
    assign bus.sout_valid = (state == SHIFT);
    assign bus.sout       = (state == SHIFT) & head;

    assign accept    = bus.load & bus.ready;
    assign cnt_clear = accept | ((state == SHIFT) & last);
    assign cnt_en    = (state == SHIFT) & ~last;

    piso_bit_counter #(.N(N)) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg <= bus.in;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shreg <= bus.in;
                    end else begin
                        shreg <= shifted;
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_piso_register.sv
// Self-checking bench for n_bit_piso_register (N=8), compares against a bit-queue model.
// Honours PISO_LSB_FIRST_EN in its model so the same bench covers both builds.
module tb_n_bit_piso_register;

    localparam int N = 8;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;

    n_bit_piso_register_if #(.N(N)) bus ();

    n_bit_piso_register #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model: queue of bits still to appear on sout, head is the current bit.
    bit exp_q[$];

    function automatic logic [7:0] tx_order(input logic [7:0] w);
        logic [7:0] r;
`ifdef PISO_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[7-i] = w[i];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic logic [3:0] exp_vec();
        logic rdy, vld, dn, so;
        rdy = (exp_q.size() <= 1);
        vld = (exp_q.size() > 0);
        dn  = (exp_q.size() == 1);
        so  = vld ? exp_q[0] : 1'b0;
        return {rdy, vld, dn, so};
    endfunction

    task automatic model_advance(input logic ld, input logic [7:0] w, output logic accepted);
        logic [7:0] t;
        accepted = ld && (exp_q.size() <= 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (accepted) begin
            t = tx_order(w);
            for (int i = 7; i >= 0; i--) exp_q.push_back(t[i]);
        end
    endtask

    function automatic logic [3:0] obs_vec();
        return {bus.ready, bus.sout_valid, bus.done, bus.sout};
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1;
        bus.load = 1'b1;
        bus.in = 8'($urandom);
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = obs_vec();
            chk_cnt++;
            if (obs !== 4'b1000) $display("FAIL reset_hold cyc=%0d got=%b exp=1000", c, obs);
            else pass_cnt++;
        end
        bus.load = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            obs = obs_vec();
            chk_cnt++;
            if (obs !== 4'b1000) $display("FAIL reset_no_capture cyc=%0d got=%b exp=1000", c, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_word();
        logic [3:0] obs;
        logic [7:0] col;
        logic       acc;
        int         dn_cnt;
        col = '0;
        dn_cnt = 0;
        bus.load = 1'b1;
        bus.in = 8'd12;
        model_advance(1'b1, 8'd12, acc);
        @(negedge clk);
        bus.load = 1'b0;
        bus.in = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            obs = obs_vec();
            chk_cnt++;
            if (obs !== exp_vec()) $display("FAIL single_word cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            else pass_cnt++;
            col = {col[6:0], bus.sout};
            if (bus.done === 1'b1) dn_cnt++;
            model_advance(1'b0, bus.in, acc);
            @(negedge clk);
        end
        chk_cnt++;
        if (col !== tx_order(8'd12)) $display("FAIL single_word_bits got=%b exp=%b", col, tx_order(8'd12));
        else pass_cnt++;
        chk_cnt++;
        if (dn_cnt != 1) $display("FAIL single_word_done got=%0d exp=1", dn_cnt);
        else pass_cnt++;
        obs = obs_vec();
        chk_cnt++;
        if (obs !== 4'b1000) $display("FAIL single_word_idle got=%b exp=1000", obs);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  obs;
        logic [15:0] col;
        logic [7:0]  words[$];
        logic        acc;
        int          dn_cnt;
        words = '{8'd39, 8'd72};
        col = '0;
        dn_cnt = 0;
        bus.load = 1'b1;
        bus.in = words[0];
        model_advance(1'b1, words[0], acc);
        if (acc) void'(words.pop_front());
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            obs = obs_vec();
            chk_cnt++;
            if (obs !== exp_vec()) $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            else pass_cnt++;
            col = {col[14:0], bus.sout};
            if (bus.done === 1'b1) dn_cnt++;
            bus.load = (words.size() > 0);
            bus.in = (words.size() > 0) ? words[0] : 8'($urandom);
            model_advance(bus.load, bus.in, acc);
            if (acc) void'(words.pop_front());
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk_cnt++;
        if (col !== {tx_order(8'd39), tx_order(8'd72)})
            $display("FAIL back_to_back_bits got=%b exp=%b", col, {tx_order(8'd39), tx_order(8'd72)});
        else pass_cnt++;
        chk_cnt++;
        if (dn_cnt != 2) $display("FAIL back_to_back_done got=%0d exp=2", dn_cnt);
        else pass_cnt++;
        obs = obs_vec();
        chk_cnt++;
        if (obs !== 4'b1000) $display("FAIL back_to_back_idle got=%b exp=1000", obs);
        else pass_cnt++;
    endtask

    task automatic test_load_while_busy();
        logic [3:0] obs;
        logic [7:0] col;
        logic       acc;
        col = '0;
        bus.load = 1'b1;
        bus.in = 8'd57;
        model_advance(1'b1, 8'd57, acc);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            obs = obs_vec();
            chk_cnt++;
            if (obs !== exp_vec()) $display("FAIL load_busy cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            else pass_cnt++;
            col = {col[6:0], bus.sout};
            bus.load = (c == 2);
            bus.in = (c == 2) ? 8'd110 : 8'($urandom);
            model_advance(bus.load, bus.in, acc);
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk_cnt++;
        if (col !== tx_order(8'd57)) $display("FAIL load_busy_bits got=%b exp=%b", col, tx_order(8'd57));
        else pass_cnt++;
        obs = obs_vec();
        chk_cnt++;
        if (obs !== 4'b1000) $display("FAIL load_busy_idle got=%b exp=1000", obs);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] obs;
        logic [7:0] col;
        logic       acc;
        bus.load = 1'b1;
        bus.in = 8'd255;
        model_advance(1'b1, 8'd255, acc);
        @(negedge clk);
        bus.load = 1'b0;
        for (int c = 0; c < 4; c++) begin
            obs = obs_vec();
            chk_cnt++;
            if (obs !== exp_vec()) $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            else pass_cnt++;
            model_advance(1'b0, bus.in, acc);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        exp_q.delete();
        obs = obs_vec();
        chk_cnt++;
        if (obs !== 4'b1000) $display("FAIL mid_reset_async got=%b exp=1000", obs);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        obs = obs_vec();
        chk_cnt++;
        if (obs !== 4'b1000) $display("FAIL mid_reset_release got=%b exp=1000", obs);
        else pass_cnt++;
        @(negedge clk);
        col = '0;
        bus.load = 1'b1;
        bus.in = 8'd1;
        model_advance(1'b1, 8'd1, acc);
        @(negedge clk);
        bus.load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            obs = obs_vec();
            chk_cnt++;
            if (obs !== exp_vec()) $display("FAIL mid_reset_post cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            else pass_cnt++;
            col = {col[6:0], bus.sout};
            model_advance(1'b0, bus.in, acc);
            @(negedge clk);
        end
        chk_cnt++;
        if (col !== tx_order(8'd1)) $display("FAIL mid_reset_bits got=%b exp=%b", col, tx_order(8'd1));
        else pass_cnt++;
    endtask

    task automatic test_random_stream();
        logic [3:0] obs;
        logic       acc;
        int         acc_cnt;
        int         dn_cnt;
        acc_cnt = 0;
        dn_cnt = 0;
        for (int c = 0; c < 320; c++) begin
            obs = obs_vec();
            chk_cnt++;
            if (obs !== exp_vec()) $display("FAIL random_stream cyc=%0d got=%b exp=%b", c, obs, exp_vec());
            else pass_cnt++;
            if (bus.done === 1'b1) dn_cnt++;
            bus.load = (c < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
            bus.in = 8'($urandom);
            model_advance(bus.load, bus.in, acc);
            if (acc) acc_cnt++;
            @(negedge clk);
        end
        chk_cnt++;
        if (dn_cnt != acc_cnt) $display("FAIL random_done_count got=%0d exp=%0d", dn_cnt, acc_cnt);
        else pass_cnt++;
    endtask

    initial begin
        chk_cnt = 0;
        pass_cnt = 0;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.in = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_load_while_busy();
        test_reset_mid_word();
        test_random_stream();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
